// File: rtl/vscale_csr_access_unit_if.sv
// Request/response and CSR-file signals of the CSR access sequencer.
// The unit sits on the slave modport; the issuing pipeline and CSR file sit on the master side.
interface vscale_csr_access_unit_if #(
  parameter int XPR_LEN    = 32,
  parameter int CSR_ADDR_W = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_cmd;
  logic [CSR_ADDR_W-1:0] req_addr;
  logic [XPR_LEN-1:0]    req_src;
  logic                  req_src_zero;
  logic [4:0]            req_rd;
  logic [1:0]            prv;
  logic                  kill;
  logic [CSR_ADDR_W-1:0] csr_addr;
  logic                  csr_en;
  logic                  csr_wen;
  logic [XPR_LEN-1:0]    csr_wdata;
  logic [XPR_LEN-1:0]    csr_rdata;
  logic                  csr_defined;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [XPR_LEN-1:0]    resp_data;
  logic [4:0]            resp_rd;
  logic                  resp_illegal;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_src, req_src_zero, req_rd, prv, kill,
           csr_rdata, csr_defined, resp_ready,
    output req_ready, csr_addr, csr_en, csr_wen, csr_wdata,
           resp_valid, resp_data, resp_rd, resp_illegal
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_src, req_src_zero, req_rd, prv, kill,
           csr_rdata, csr_defined, resp_ready,
    input  req_ready, csr_addr, csr_en, csr_wen, csr_wdata,
           resp_valid, resp_data, resp_rd, resp_illegal
  );
endinterface

// File: rtl/vscale_csr_access_unit.sv
// CSR instruction sequencer: read old value, check permission, read-modify-write,
// then hand the old value (or an illegal-instruction flag) back to writeback.
module vscale_csr_access_unit #(
  parameter int XPR_LEN    = 32,
  parameter int CSR_ADDR_W = 12
) (
  input logic                      clk,
  input logic                      reset,
  vscale_csr_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state;
  logic [2:0]            cmd_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XPR_LEN-1:0]    src_q;
  logic                  src_zero_q;
  logic [4:0]            rd_q;
  logic [XPR_LEN-1:0]    old_q;
  logic [XPR_LEN-1:0]    wdata_q;
  logic                  ready_q;
  logic                  en_q;
  logic                  wen_q;
  logic                  valid_q;
  logic [XPR_LEN-1:0]    data_q;
  logic                  illegal_q;

  logic                  write_intent;
  logic                  illegal;
  logic [XPR_LEN-1:0]    rmw;

  // Decisions made during RD, from the captured request and the live CSR read
  always_comb begin
    write_intent = (cmd_q[1:0] == 2'd1) || ((cmd_q[1:0] != 2'd0) && !src_zero_q);
    illegal      = (cmd_q[1:0] == 2'd0) || !bus.csr_defined ||
                   (bus.prv < addr_q[9:8]) ||
                   (write_intent && (addr_q[11:10] == 2'b11));
    case (cmd_q[1:0])
      2'd2:    rmw = bus.csr_rdata | src_q;
      2'd3:    rmw = bus.csr_rdata & ~src_q;
      default: rmw = src_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      rd_q       <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b1;
      en_q       <= 1'b0;
      wen_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      illegal_q  <= 1'b0;
    end else if (bus.kill) begin
      // Flush drops whatever is in flight, including an undelivered response
      state   <= IDLE;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          cmd_q      <= bus.req_cmd;
          addr_q     <= bus.req_addr;
          src_q      <= bus.req_src;
          src_zero_q <= bus.req_src_zero;
          rd_q       <= bus.req_rd;
          ready_q    <= 1'b0;
          en_q       <= 1'b1;
          state      <= RD;
        end
        RD: begin
          old_q <= bus.csr_rdata;
          if (illegal || !write_intent) begin
            en_q      <= 1'b0;
            valid_q   <= 1'b1;
            data_q    <= illegal ? '0 : bus.csr_rdata;
            illegal_q <= illegal;
            state     <= RESP;
          end else begin
            wen_q   <= 1'b1;
            wdata_q <= rmw;
            state   <= WR;
          end
        end
        WR: begin
          en_q      <= 1'b0;
          wen_q     <= 1'b0;
          valid_q   <= 1'b1;
          data_q    <= old_q;
          illegal_q <= 1'b0;
          state     <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe is gated live so a same-cycle kill or reset blocks the write
  assign bus.csr_wen      = wen_q & ~bus.kill & ~reset;
  assign bus.csr_wdata    = bus.csr_wen ? wdata_q : '0;
  assign bus.csr_en       = en_q;
  assign bus.csr_addr     = addr_q;
  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = valid_q;
  assign bus.resp_data    = data_q;
  assign bus.resp_rd      = rd_q;
  assign bus.resp_illegal = illegal_q;

endmodule

// File: tb/tb_vscale_csr_access_unit.sv
// Scoreboard bench for the CSR access sequencer: a CSR-file model, a driver that
// predicts each response and write, and monitors that check what the unit presents.
module tb_vscale_csr_access_unit;
  localparam int XL = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vscale_csr_access_unit_if #(.XPR_LEN(XL), .CSR_ADDR_W(AW)) bus ();
  vscale_csr_access_unit #(.XPR_LEN(XL), .CSR_ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] data; logic [4:0] rd; logic ill; int acc; int lat; } rexp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; int acc; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // CSR file model: one process owns the storage
  logic [31:0] mem [0:4095];
  logic        poke = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  assign bus.csr_rdata   = mem[bus.csr_addr];
  assign bus.csr_defined = (bus.csr_addr[7:4] != 4'hF);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke) mem[poke_addr] <= poke_data;
    else if (bus.csr_wen) mem[bus.csr_addr] <= bus.csr_wdata;
  end

  logic force_low = 1'b0;
  always @(posedge clk) begin
    #1 bus.resp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: architectural meaning of each CSR instruction
  task automatic model(input logic [2:0] cmd, input logic [11:0] a, input logic [31:0] src,
                       input logic [1:0] p, input logic [31:0] old,
                       output bit ill, output bit wr, output logic [31:0] nv);
    bit is_rw, is_rs, is_rc;
    is_rw = (cmd == 3'd1) || (cmd == 3'd5);
    is_rs = (cmd == 3'd2) || (cmd == 3'd6);
    is_rc = (cmd == 3'd3) || (cmd == 3'd7);
    wr  = is_rw || ((is_rs || is_rc) && src != 0);
    ill = !(is_rw || is_rs || is_rc) || (a[7:4] == 4'hF) || (p < a[9:8]) ||
          (wr && a[11:10] == 2'b11);
    nv  = is_rw ? src : is_rs ? (old | src) : (old & ~src);
  endtask

  // Monitors: writes to the CSR file and responses to writeback
  bit    in_resp = 0;
  rexp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      in_resp = 0;
    end else begin
      if (bus.csr_wen) begin
        if (wq.size() == 0) flag("unexpected_csr_wen");
        else begin
          wexp_t w;
          w = wq.pop_front();
          chk("wen_addr", 32'(bus.csr_addr), 32'(w.addr));
          chk("wen_data", bus.csr_wdata, w.data);
          chk("wen_latency", 32'(cyc - w.acc), 32'd2);
        end
      end else begin
        chk("wdata_idle", bus.csr_wdata, 32'd0);
      end
      if (bus.resp_valid) begin
        if (!in_resp) begin
          if (rq.size() == 0) flag("unexpected_resp");
          else begin
            cur = rq.pop_front();
            chk("resp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end
          in_resp = 1;
        end else begin
          chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        end
        chk("resp_data", bus.resp_data, cur.data);
        chk("resp_rd", 32'(bus.resp_rd), 32'(cur.rd));
        chk("resp_illegal", 32'(bus.resp_illegal), 32'(cur.ill));
        if (bus.resp_ready) in_resp = 0;
      end else begin
        in_resp = 0;
      end
    end
  end

  // Driver runs at posedge+1; waits till the unit is past RD/WR
  task automatic wait_not_busy();
    int k = 0;
    while (bus.csr_en && k < 20) begin @(posedge clk); #1; k++; end
    if (bus.csr_en) flag("busy_timeout");
  endtask

  task automatic do_poke(input logic [11:0] a, input logic [31:0] d);
    wait_not_busy();
    poke_addr = a; poke_data = d; poke = 1'b1;
    @(posedge clk); #1;
    poke = 1'b0;
  endtask

  task automatic send(input logic [2:0] cmd, input logic [11:0] a, input logic [31:0] src,
                      input logic [1:0] p, input logic [4:0] rd, input bit track);
    int k = 0;
    bit ill, wr;
    logic [31:0] nv, old;
    wait_not_busy();
    bus.req_cmd = cmd; bus.req_addr = a; bus.req_src = src; bus.req_src_zero = (src == 0);
    bus.req_rd = rd; bus.prv = p; bus.req_valid = 1'b1;
    while (!bus.req_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!bus.req_ready) begin
      flag("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (track) begin
      old = mem[a];
      model(cmd, a, src, p, old, ill, wr, nv);
      rq.push_back('{ill ? 32'd0 : old, rd, ill, cyc - 1, (ill || !wr) ? 2 : 3});
      if (!ill && wr) wq.push_back('{a, nv, cyc - 1});
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((!bus.req_ready || rq.size() != 0) && k < 200) begin @(posedge clk); #1; k++; end
    if (!bus.req_ready) flag("idle_timeout");
  endtask

  logic [11:0] alist [8];
  logic [31:0] keep;

  initial begin
    alist = '{12'h340, 12'h300, 12'hC00, 12'h305, 12'h3F0, 12'h100, 12'h041, 12'h7F0};
    bus.req_valid = 0; bus.req_cmd = 0; bus.req_addr = 0; bus.req_src = 0;
    bus.req_src_zero = 0; bus.req_rd = 0; bus.prv = 0; bus.kill = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_csr_en", 32'(bus.csr_en), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_illegal", 32'(bus.resp_illegal), 32'd0);
    @(posedge clk); #1;

    // Directed cases
    do_poke(12'h340, 32'h12345678);
    send(3'd1, 12'h340, 32'hDEADBEEF, 2'd3, 5'd5, 1);
    do_poke(12'hC00, 32'hCAFE0001);
    send(3'd2, 12'hC00, 32'd0, 2'd0, 5'd6, 1);
    do_poke(12'h300, 32'h6);
    send(3'd3, 12'h300, 32'h2, 2'd3, 5'd7, 1);
    do_poke(12'h300, 32'h6);
    send(3'd6, 12'h300, 32'h1, 2'd3, 5'd8, 1);
    send(3'd1, 12'hC00, 32'h5, 2'd3, 5'd9, 1);
    send(3'd2, 12'h300, 32'd0, 2'd0, 5'd10, 1);
    send(3'd2, 12'h3F0, 32'd0, 2'd3, 5'd11, 1);
    wait_idle();

    // Held response: next request must wait for the handshake
    force_low = 1'b1;
    send(3'd1, 12'h305, 32'h0BADF00D, 2'd3, 5'd12, 1);
    fork begin repeat (7) @(posedge clk); force_low = 1'b0; end join_none
    send(3'd2, 12'h305, 32'd0, 2'd3, 5'd13, 1);
    wait_idle();

    // Kill during WR
    keep = mem[12'h340];
    send(3'd1, 12'h340, 32'hAAAA5555, 2'd3, 5'd14, 0);
    @(posedge clk); #1;
    bus.kill = 1'b1;
    @(negedge clk);
    chk("kill_wen", 32'(bus.csr_wen), 32'd0);
    @(posedge clk); #1;
    bus.kill = 1'b0;
    chk("kill_req_ready", 32'(bus.req_ready), 32'd1);
    chk("kill_csr_en", 32'(bus.csr_en), 32'd0);
    chk("kill_mem_kept", mem[12'h340], keep);

    // Reset during RD
    send(3'd1, 12'h340, 32'h11112222, 2'd3, 5'd15, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd_wen", 32'(bus.csr_wen), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstrd_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstrd_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstrd_csr_en", 32'(bus.csr_en), 32'd0);
    chk("rstrd_mem_kept", mem[12'h340], keep);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  cmd;
      logic [11:0] a;
      logic [31:0] src;
      logic [1:0]  p;
      int          s;
      cmd = 3'($urandom_range(0, 7));
      s   = $urandom_range(0, 8);
      a   = (s == 8) ? 12'($urandom) : alist[s];
      if (cmd[2]) src = 32'($urandom_range(0, 31));
      else        src = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      s = $urandom_range(0, 2);
      p = (s == 0) ? 2'd0 : (s == 1) ? 2'd1 : 2'd3;
      if ($urandom_range(0, 1) == 0) do_poke(a, $urandom);
      send(cmd, a, src, p, 5'($urandom), 1);
    end
    wait_idle();
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("wen_queue_drained", 32'(wq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end
endmodule
